// File: rtl/nregister_shift_bank.sv
// Bank of LANES independent WIDTH-bit registers with masked load, shift, rotate and clear.
// Every output is a direct register output; there is no combinational path from the inputs.
module nregister_shift_bank #(
   parameter int               WIDTH     = 8,
   parameter int               LANES     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   io_clear,
   input  logic [LANES-1:0]       io_enable,
   input  logic [2:0]             io_mode,
   input  logic [LANES*WIDTH-1:0] io_D,
   input  logic [WIDTH-1:0]       io_mask,
   input  logic [LANES-1:0]       io_sin,
   output logic [LANES*WIDTH-1:0] io_Q,
   output logic [LANES-1:0]       io_sout,
   output logic [LANES-1:0]       io_changed
);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROTL = 3'b100,
      MODE_ROTR = 3'b101
   } mode_e;

   logic [LANES-1:0][WIDTH-1:0] q, q_next;
   logic [LANES-1:0]            sout, sout_next;
   logic [LANES-1:0]            changed, changed_next;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can leave
      // it unassigned and infer a latch.
      q_next       = q;
      sout_next    = sout;
      changed_next = '0;
      for (int i = 0; i < LANES; i++) begin
         if (io_clear) begin
            q_next[i]    = RESET_VAL;
            sout_next[i] = 1'b0;
         end else if (io_enable[i]) begin
            case (io_mode)
               MODE_LOAD: q_next[i] = (io_D[i*WIDTH +: WIDTH] & io_mask) | (q[i] & ~io_mask);
               MODE_SHL: begin
                  q_next[i]    = {q[i][WIDTH-2:0], io_sin[i]};
                  sout_next[i] = q[i][WIDTH-1];
               end
               MODE_SHR: begin
                  q_next[i]    = {io_sin[i], q[i][WIDTH-1:1]};
                  sout_next[i] = q[i][0];
               end
               MODE_ROTL: begin
                  q_next[i]    = {q[i][WIDTH-2:0], q[i][WIDTH-1]};
                  sout_next[i] = q[i][WIDTH-1];
               end
               MODE_ROTR: begin
                  q_next[i]    = {q[i][0], q[i][WIDTH-1:1]};
                  sout_next[i] = q[i][0];
               end
               default: q_next[i] = q[i];  // hold and the two unused 11x codes
            endcase
         end
         // Value comparison, so identical loads and uniform rotates do not flag a change.
         changed_next[i] = (q_next[i] != q[i]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update
   // together from pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q       <= {LANES{RESET_VAL}};
         sout    <= '0;
         changed <= '0;
      end else begin
         q       <= q_next;
         sout    <= sout_next;
         changed <= changed_next;
      end
   end

   assign io_Q       = q;
   assign io_sout    = sout;
   assign io_changed = changed;

endmodule
